// File: rtl/trap_seq.sv
// Machine-mode trap/return sequencer: drains the pipeline, strobes the CSR block, redirects the PC.
// Optional macro TRAP_SEQ_VECTORED_EN enables vectored trap targets (mtvec[1:0]==2'b01).
module trap_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mip,
  input  logic [31:0] mie,
  input  logic        MIE,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        csr_en,
  input  logic        mret_req,
  input  logic        flush_ack,
  output logic        flush_req,
  output logic        stall,
  output logic        int_action,
  output logic        ret_action,
  output logic        hw_int,
  output logic [4:0]  int_code,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAIN     = 3'd1,
    COMMIT    = 3'd2,
    REDIRECT  = 3'd3,
    RET       = 3'd4,
    RET_REDIR = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pend;
  logic        take;
  logic        latch_cause;
  logic [4:0]  cause;
  logic [31:0] trap_base;
  logic [31:0] trap_target;

  assign pend        = mip & mie & 32'hFFFF_0888;
  assign take        = MIE & (|pend);
  assign latch_cause = (state == IDLE) && !csr_en && take;
  assign trap_base   = {mtvec[31:2], 2'b00};

  // Fixed priority 11 > 3 > 7, then platform causes with the lowest index winning.
  always_comb begin
    cause = 5'd0;
    if (pend[11])     cause = 5'd11;
    else if (pend[3]) cause = 5'd3;
    else if (pend[7]) cause = 5'd7;
    else begin
      for (int i = 31; i >= 16; i--) begin
        if (pend[i]) cause = 5'(i);
      end
    end
  end

`ifdef TRAP_SEQ_VECTORED_EN
  always_comb begin
    trap_target = trap_base;
    if (mtvec[1:0] == 2'b01) trap_target = trap_base + {25'd0, int_code, 2'b00};
  end
`else
  logic unused_mode;
  assign unused_mode = ^mtvec[1:0];
  always_comb begin
    trap_target = trap_base;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!csr_en) begin
          if (take)          state_nxt = DRAIN;
          else if (mret_req) state_nxt = RET;
        end
      end
      DRAIN:     if (flush_ack) state_nxt = COMMIT;
      COMMIT:    state_nxt = REDIRECT;
      REDIRECT:  state_nxt = IDLE;
      RET:       state_nxt = RET_REDIR;
      RET_REDIR: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      flush_req      <= 1'b0;
      stall          <= 1'b0;
      int_action     <= 1'b0;
      ret_action     <= 1'b0;
      hw_int         <= 1'b0;
      redirect_valid <= 1'b0;
      int_code       <= 5'd0;
      redirect_pc    <= 32'd0;
    end else begin
      state          <= state_nxt;
      flush_req      <= (state_nxt == DRAIN);
      stall          <= (state_nxt != IDLE);
      int_action     <= (state_nxt == COMMIT);
      hw_int         <= (state_nxt == COMMIT);
      ret_action     <= (state_nxt == RET);
      redirect_valid <= (state_nxt == REDIRECT) || (state_nxt == RET_REDIR);
      if (latch_cause)              int_code    <= cause;
      if (state_nxt == REDIRECT)    redirect_pc <= trap_target;
      if (state_nxt == RET_REDIR)   redirect_pc <= mepc;
    end
  end

endmodule

// File: tb/tb_trap_seq.sv
// Bench for trap_seq: vector table plus hand sequences, redirects checked against a scoreboard queue.
module tb_trap_seq;
  logic        clk;
  logic        reset_n;
  logic [31:0] mip, mie, mtvec, mepc;
  logic        gie, csr_en, mret_req, flush_ack;
  logic        flush_req, stall, int_action, ret_action, hw_int, redirect_valid;
  logic [4:0]  int_code;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad = 0;
  int int_cnt = 0;
  int ret_cnt = 0;

  localparam logic [1:0] K_NONE = 2'd0, K_INT = 2'd1, K_RET = 2'd2;

  typedef struct {
    logic [31:0] mip;
    logic [31:0] mie;
    logic        gie;
    logic [31:0] mtvec;
    logic        mret;
    logic [31:0] mepc;
    logic [1:0]  kind;
    logic [4:0]  code;
    logic [31:0] pc_base;
    logic [31:0] pc_vec;
  } vec_t;

  typedef struct {
    logic        is_int;
    logic [4:0]  code;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  vec_t vt[12];

  trap_seq dut (
    .clk(clk), .reset_n(reset_n), .mip(mip), .mie(mie), .MIE(gie),
    .mtvec(mtvec), .mepc(mepc), .csr_en(csr_en), .mret_req(mret_req),
    .flush_ack(flush_ack), .flush_req(flush_req), .stall(stall),
    .int_action(int_action), .ret_action(ret_action), .hw_int(hw_int),
    .int_code(int_code), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (int_action) int_cnt++;
    if (ret_action) ret_cnt++;
    if (redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_redirect: got pc 0x%0h with empty scoreboard", redirect_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("redirect_pc", redirect_pc, e.pc);
        if (e.is_int) check("code_at_redirect", {27'd0, int_code}, {27'd0, e.code});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_req();
    mip = 32'd0; mie = 32'd0; gie = 1'b0; mret_req = 1'b0;
  endtask

  // Called one cycle after a take: DRAIN held, ack, COMMIT pulse, REDIRECT, back to IDLE.
  task automatic finish_int(input logic [4:0] code, input int i0, input int r0);
    check("flush_req_after_take", {31'd0, flush_req}, 32'd1);
    check("stall_in_drain", {31'd0, stall}, 32'd1);
    check("no_ret_on_int", {31'd0, ret_action}, 32'd0);
    clear_req();
    step();
    check("drain_hold", {31'd0, flush_req}, 32'd1);
    flush_ack = 1'b1;
    step();
    check("int_action", {31'd0, int_action}, 32'd1);
    check("hw_int", {31'd0, hw_int}, 32'd1);
    check("int_code", {27'd0, int_code}, {27'd0, code});
    check("flush_req_drop", {31'd0, flush_req}, 32'd0);
    flush_ack = 1'b0;
    step();
    check("redirect_valid_int", {31'd0, redirect_valid}, 32'd1);
    check("int_action_one_cycle", {31'd0, int_action}, 32'd0);
    check("int_pulses", int_cnt - i0, 32'd1);
    check("ret_pulses_on_int", ret_cnt - r0, 32'd0);
    step();
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("redirect_one_cycle", {31'd0, redirect_valid}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int   i0, r0;
    exp_t e;
    i0 = int_cnt;
    r0 = ret_cnt;
    mip = v.mip; mie = v.mie; gie = v.gie; mtvec = v.mtvec;
    mret_req = v.mret; mepc = v.mepc;
    e.is_int = (v.kind == K_INT);
    e.code   = v.code;
`ifdef TRAP_SEQ_VECTORED_EN
    e.pc = v.pc_vec;
`else
    e.pc = v.pc_base;
`endif
    if (v.kind != K_NONE) exp_q.push_back(e);
    step();
    if (v.kind == K_INT) begin
      finish_int(v.code, i0, r0);
    end else if (v.kind == K_RET) begin
      check("ret_action", {31'd0, ret_action}, 32'd1);
      check("no_flush_on_ret", {31'd0, flush_req}, 32'd0);
      check("stall_in_ret", {31'd0, stall}, 32'd1);
      step();
      check("redirect_valid_ret", {31'd0, redirect_valid}, 32'd1);
      check("ret_action_one_cycle", {31'd0, ret_action}, 32'd0);
      check("ret_pulses", ret_cnt - r0, 32'd1);
      check("int_pulses_on_ret", int_cnt - i0, 32'd0);
      clear_req();
      step();
      check("idle_after_ret", {31'd0, stall}, 32'd0);
    end else begin
      check("no_flush_idle", {31'd0, flush_req}, 32'd0);
      check("no_ret_idle", {31'd0, ret_action}, 32'd0);
      check("no_stall_idle", {31'd0, stall}, 32'd0);
      clear_req();
      step();
    end
  endtask

  initial begin
    int i0, r0;
    exp_t e;
    vt[0]  = '{32'h80,        32'h80,        1'b1, 32'h100,       1'b0, 32'h0,         K_INT,  5'd7,  32'h100,       32'h100};
    vt[1]  = '{32'h888,       32'h888,       1'b1, 32'h201,       1'b0, 32'h0,         K_INT,  5'd11, 32'h200,       32'h22C};
    vt[2]  = '{32'h0,         32'h0,         1'b1, 32'h100,       1'b1, 32'h8000_0040, K_RET,  5'd0,  32'h8000_0040, 32'h8000_0040};
    vt[3]  = '{32'h8,         32'h8,         1'b1, 32'h100,       1'b1, 32'h8000_0040, K_INT,  5'd3,  32'h100,       32'h100};
    vt[4]  = '{32'h888,       32'h888,       1'b0, 32'h100,       1'b0, 32'h0,         K_NONE, 5'd0,  32'h0,         32'h0};
    vt[5]  = '{32'h20,        32'hFFFF_FFFF, 1'b1, 32'h100,       1'b0, 32'h0,         K_NONE, 5'd0,  32'h0,         32'h0};
    vt[6]  = '{32'h0003_0000, 32'hFFFF_FFFF, 1'b1, 32'h101,       1'b0, 32'h0,         K_INT,  5'd16, 32'h100,       32'h140};
    vt[7]  = '{32'h8000_0088, 32'hFFFF_FFFF, 1'b1, 32'h100,       1'b0, 32'h0,         K_INT,  5'd3,  32'h100,       32'h100};
    vt[8]  = '{32'h8000_0080, 32'hFFFF_FFFF, 1'b1, 32'h100,       1'b0, 32'h0,         K_INT,  5'd7,  32'h100,       32'h100};
    vt[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'h0,         K_INT,  5'd31, 32'hFFFF_FFFC, 32'h0000_0078};
    vt[10] = '{32'hFFFF_FFFF, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0,         K_NONE, 5'd0,  32'h0,         32'h0};
    vt[11] = '{32'h6000_0000, 32'hFFFF_FFFF, 1'b1, 32'h301,       1'b0, 32'h0,         K_INT,  5'd29, 32'h300,       32'h374};

    reset_n = 1'b0; csr_en = 1'b0; flush_ack = 1'b0; mtvec = 32'h100; mepc = 32'h0;
    clear_req();
    step();
    step();
    check("rst_flush_req", {31'd0, flush_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_int_action", {31'd0, int_action}, 32'd0);
    check("rst_ret_action", {31'd0, ret_action}, 32'd0);
    check("rst_hw_int", {31'd0, hw_int}, 32'd0);
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_int_code", {27'd0, int_code}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    reset_n = 1'b1;
    step();

    for (int k = 0; k < 12; k++) run_vec(vt[k]);

    // CSR instruction in flight defers the take until csr_en falls.
    i0 = int_cnt; r0 = ret_cnt;
    mip = 32'h8; mie = 32'h8; gie = 1'b1; mret_req = 1'b1; mtvec = 32'h100; csr_en = 1'b1;
    e.is_int = 1'b1; e.code = 5'd3; e.pc = 32'h100;
    exp_q.push_back(e);
    for (int c = 0; c < 3; c++) begin
      step();
      check("csr_defer_flush", {31'd0, flush_req}, 32'd0);
      check("csr_defer_ret", {31'd0, ret_action}, 32'd0);
    end
    csr_en = 1'b0;
    step();
    finish_int(5'd3, i0, r0);

    // Reset while draining aborts with no trap strobes.
    i0 = int_cnt;
    mip = 32'h80; mie = 32'h80; gie = 1'b1; mtvec = 32'h100;
    step();
    check("pre_reset_drain", {31'd0, flush_req}, 32'd1);
    clear_req();
    step();
    #2;
    reset_n = 1'b0;
    flush_ack = 1'b1;
    #1;
    check("mid_rst_flush_req", {31'd0, flush_req}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_int_code", {27'd0, int_code}, 32'd0);
    check("mid_rst_redirect_pc", redirect_pc, 32'd0);
    check("mid_rst_strobes", {28'd0, int_action, ret_action, hw_int, redirect_valid}, 32'd0);
    step();
    step();
    check("no_int_after_abort", int_cnt - i0, 32'd0);
    flush_ack = 1'b0;
    reset_n = 1'b1;
    step();
    check("post_rst_idle", {31'd0, stall}, 32'd0);
    run_vec(vt[0]);

    step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_seq.md
TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 SHALL have port clk  input  1  core clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port mip  input  32  pending-interrupt bits from CSR block.
REQ-004 SHALL have port mie  input  32  interrupt-enable bits from CSR block.
REQ-005 SHALL have port MIE  input  1  global machine interrupt enable.
REQ-006 SHALL have port mtvec  input  32  trap vector base/mode.
REQ-007 SHALL have port mepc  input  32  saved return PC.
REQ-008 SHALL have port csr_en  input  1  CSR instruction in flight; defers trap/return decisions.
REQ-009 SHALL have port mret_req  input  1  decoded MRET at commit point; level, held until redirect.
REQ-010 SHALL have port flush_ack  input  1  pipeline drained and flushed.
REQ-011 SHALL have port flush_req  output  1  request pipeline drain/flush.
REQ-012 SHALL have port stall  output  1  freeze fetch/issue while busy.
REQ-013 SHALL have port int_action  output  1  one-cycle trap-entry strobe to CSR block.
REQ-014 SHALL have port ret_action  output  1  one-cycle return strobe to CSR block.
REQ-015 SHALL have port hw_int  output  1  trap is a hardware interrupt; valid with int_action.
REQ-016 SHALL have port int_code  output  5  latched interrupt cause.
REQ-017 SHALL have port redirect_valid  output  1  one-cycle PC redirect strobe.
REQ-018 SHALL have port redirect_pc  output  32  redirect target; valid with redirect_valid.

Function
REQ-019 SHALL implement states IDLE, DRAIN, COMMIT, REDIRECT, RET, RET_REDIR; all outputs registered.
REQ-020 In IDLE with csr_en=0: take = MIE & |(mip & mie & 32'hFFFF_0888); take -> DRAIN, latch int_code.
REQ-021 Priority SHALL be cause 11 > 3 > 7 > 16..31 (lowest index first); bits outside the mask SHALL be ignored.
REQ-022 In IDLE, take=1 together with mret_req=1 SHALL select the interrupt; mret_req is ignored (MRET is flushed).
REQ-023 In IDLE with csr_en=1, no transition SHALL occur regardless of take or mret_req.
REQ-024 In IDLE, mret_req=1 with take=0 and csr_en=0 -> RET.
REQ-025 DRAIN SHALL hold flush_req=1 and stall=1 until flush_ack=1 is sampled, then -> COMMIT; no timeout.
REQ-026 Once latched, the trap SHALL commit even if mip/mie/MIE deassert during DRAIN.
REQ-027 COMMIT SHALL assert int_action=1 and hw_int=1 for exactly one cycle, then -> REDIRECT.
REQ-028 REDIRECT SHALL assert redirect_valid=1 for one cycle with the trap target (REQ-035), then -> IDLE.
REQ-029 RET SHALL assert ret_action=1 for one cycle, then -> RET_REDIR.
REQ-030 RET_REDIR SHALL assert redirect_valid=1 with redirect_pc=mepc sampled that cycle, then -> IDLE.
REQ-031 stall SHALL be 1 in every state except IDLE; int_code SHALL hold its value until the next take.
REQ-032 Latency: take sampled in cycle N gives flush_req=1 in N+1; flush_ack sampled in M gives int_action in M+1 and redirect_valid in M+2.
REQ-033 IDLE decisions SHALL be re-evaluated every cycle; no request is queued.

Reset
REQ-034 While reset_n=0: state IDLE; flush_req, stall, int_action, ret_action, hw_int and redirect_valid = 0; int_code=5'd0; redirect_pc=32'd0; reset mid-sequence aborts with no strobes emitted.

Configuration
REQ-035 Macro TRAP_SEQ_VECTORED_EN: defined -> target = {mtvec[31:2],2'b00} + 4*int_code when mtvec[1:0]=2'b01, otherwise base; undefined -> always base, mtvec[1:0] ignored. Addition SHALL wrap modulo 2^32.

Verification
REQ-036 MIE=1, mie[7]=mip[7]=1, mtvec=0x100, flush_ack one cycle after flush_req -> int_code=7, one int_action pulse, redirect_pc=0x100.
REQ-037 mip=mie=0x888, MIE=1, mtvec=0x201 with TRAP_SEQ_VECTORED_EN -> int_code=11, redirect_pc=0x22C; macro undefined -> 0x200.
REQ-038 mret_req=1, mepc=0x8000_0040, no pending interrupt -> ret_action pulse, then redirect_pc=0x8000_0040 in the following cycle.
REQ-039 mret_req and mip[3]=mie[3]=1 with MIE=1 in the same cycle -> interrupt path (int_code=3), ret_action never asserted.
REQ-040 csr_en=1 held 3 cycles with interrupt pending -> no flush_req until the cycle after csr_en falls.
REQ-041 reset_n low while in DRAIN -> all outputs 0 immediately and no int_action emitted; normal operation after release.
